// File: rtl/boot_rom_pkg.sv
// Shared definitions for the boot ROM bus adapter.
// Holds the default ROM geometry, the default window base, and the
// response record that travels through the response FIFO.
package boot_rom_pkg;

  localparam int          ROM_WORDS_DEF  = 548;
  localparam int          ROM_ADDR_W_DEF = 10;
  localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_8000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } boot_resp_t;

endpackage

// File: rtl/boot_rom_resp_fifo.sv
// Small in-order synchronous FIFO of boot_resp_t records.
// Ports:
//   CLK, RSTN   clock, synchronous active-low reset (clears storage too)
//   push        write push_data at the tail
//   push_data   record to enqueue
//   pop         drop the head entry
//   head        current head record (valid when !empty)
//   full, empty occupancy flags
//   cnt         number of stored entries
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  boot_resp_t       push_data,
  input  logic             pop,
  output boot_resp_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  boot_resp_t       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] wen;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt_reg == CNT_W'(DEPTH));
  assign empty = (cnt_reg == '0);
  assign cnt   = cnt_reg;
  assign head  = mem_reg[rd_ptr_reg];

  // A push into a full FIFO is legal only when the head leaves in the
  // same cycle; the slot being written is then the one being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wen
      assign wen[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) mem_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      cnt_reg <= cnt_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/boot_rom_bus_adapter.sv
// Bus-slave front end for the boot ROM macro.
// Accepts req/gnt requests, drives the ROM chip select and word address,
// captures ROM data one cycle later and returns responses in order through
// a small valid/ready response FIFO. Writes and out-of-window addresses are
// answered with err=1, rdata=0 and never select the ROM.
// Ports:
//   CLK, RSTN             clock, synchronous active-low reset
//   req_i / gnt_o         request valid / accepted this cycle (combinational)
//   addr_i, we_i          byte address (bits [1:0] ignored), write enable
//   be_i, wdata_i         unused write-side fields
//   r_valid_o/r_ready_i   response handshake
//   r_rdata_o, r_err_o    response payload from the FIFO head
//   rom_csn_o, rom_a_o    ROM chip select (active low), word address
//   rom_q_i               ROM data, valid the cycle after a CSN-low edge
module boot_rom_bus_adapter
  import boot_rom_pkg::*;
#(
  parameter int          ROM_WORDS  = ROM_WORDS_DEF,
  parameter int          ROM_ADDR_W = ROM_ADDR_W_DEF,
  parameter logic [31:0] BASE_ADDR  = BOOT_BASE_ADDR,
  parameter int          RESP_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [31:0]           r_rdata_o,
  output logic                  r_err_o,
  output logic                  rom_csn_o,
  output logic [ROM_ADDR_W-1:0] rom_a_o,
  input  logic [31:0]           rom_q_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ROM_ADDR_W-1:0] idx;
  logic                  in_win;
  logic                  err_req;
  logic                  pop;
  logic [OCC_W-1:0]      occ;
  logic                  space;

  logic                  inflight_reg;
  logic                  inflight_err_reg;

  boot_resp_t            push_data;
  boot_resp_t            fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_cnt;

  // Address decode
  assign idx     = addr_i[ROM_ADDR_W+1:2];
  assign in_win  = (addr_i[31:ROM_ADDR_W+2] == BASE_ADDR[31:ROM_ADDR_W+2]) &&
                   (32'(idx) < 32'(ROM_WORDS));
  assign err_req = we_i || !in_win;

  // Occupancy counts everything already committed to the FIFO: stored
  // entries plus the one in flight, minus the head leaving this cycle.
  // One extra bit keeps the sum from wrapping.
  assign pop   = r_valid_o && r_ready_i;
  assign occ   = {1'b0, fifo_cnt} + OCC_W'(inflight_reg) - OCC_W'(pop);
  assign space = (occ < OCC_W'(RESP_DEPTH));

  assign gnt_o     = RSTN && req_i && space;
  assign rom_csn_o = !(gnt_o && !err_req);
  assign rom_a_o   = idx;

  // In-flight stage: remembers that the ROM (or an error) answers next cycle
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      inflight_reg     <= 1'b0;
      inflight_err_reg <= 1'b0;
    end else begin
      inflight_reg     <= gnt_o;
      inflight_err_reg <= gnt_o && err_req;
    end
  end

  // rom_q_i only reaches the FIFO storage, never an output directly
  assign push_data.rdata = inflight_err_reg ? 32'h0 : rom_q_i;
  assign push_data.err   = inflight_err_reg;

  boot_rom_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (fifo_cnt)
  );

  assign r_valid_o = !fifo_empty;
  assign r_rdata_o = fifo_head.rdata;
  assign r_err_o   = fifo_head.err;

  logic unused_ok;
  assign unused_ok = ^{be_i, wdata_i, addr_i[1:0], fifo_full};

endmodule

// File: tb/tb_boot_rom_bus_adapter.sv
module tb_boot_rom_bus_adapter;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          WORDS = 548;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic [31:0] r_rdata_o;
  logic        r_err_o;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q_i = '0;

  always #5 CLK = ~CLK;

  boot_rom_bus_adapter dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .wdata_i   (wdata_i),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .r_rdata_o (r_rdata_o),
    .r_err_o   (r_err_o),
    .rom_csn_o (rom_csn_o),
    .rom_a_o   (rom_a_o),
    .rom_q_i   (rom_q_i)
  );

  // ROM macro model: data appears the cycle after a CSN-low edge
  logic [31:0] mem [1024];
  always @(posedge CLK) begin
    if (!rom_csn_o) rom_q_i <= mem[rom_a_o];
  end

  // Reference model: queue of accepted requests with the cycle of grant
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          gcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   post_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic void expect_resp(input logic [31:0] a, input logic w,
                                      output logic [31:0] d, output logic e);
    logic [31:0] aa;
    aa = a & ~32'h3;
    if (!w && aa >= BASE && aa < BASE + 32'(4 * WORDS)) begin
      d = mem[(aa - BASE) >> 2];
      e = 1'b0;
    end else begin
      d = 32'h0;
      e = 1'b1;
    end
  endfunction

  task automatic cycle(input logic rst_n, input logic rq, input logic [31:0] a,
                       input logic w, input logic rdy, input bit do_chk);
    logic        exp_valid, exp_pop, exp_gnt, exp_err;
    logic [31:0] exp_data;
    exp_t        ent;
    @(negedge CLK);
    RSTN = rst_n; req_i = rq; addr_i = a; we_i = w; r_ready_i = rdy;
    be_i = 4'($urandom); wdata_i = $urandom;
    #1;
    exp_valid = (q.size() > 0) && (cyc >= q[0].gcyc + 2);
    exp_pop   = exp_valid && rdy;
    exp_gnt   = rst_n && rq && ((q.size() - int'(exp_pop)) < 2);
    expect_resp(a, w, exp_data, exp_err);
    if (do_chk) begin
      chk("gnt", 32'(gnt_o), 32'(exp_gnt));
      chk("csn", 32'(rom_csn_o), 32'(!(exp_gnt && !exp_err)));
      chk("rom_a", 32'(rom_a_o), 32'(a[11:2]));
      chk("r_valid", 32'(r_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        chk("rdata", r_rdata_o, q[0].data);
        chk("err", 32'(r_err_o), 32'(q[0].err));
      end
      if (post_rst) begin
        chk("rst_rdata", r_rdata_o, 32'h0);
        chk("rst_err", 32'(r_err_o), 32'h0);
      end
    end
    @(posedge CLK);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_gnt) begin
        ent.data = exp_data; ent.err = exp_err; ent.gcyc = cyc;
        q.push_back(ent);
      end
    end
    post_rst = !rst_n;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, rdy, 1'b1);
  endtask

  logic [31:0] ra;
  int          kind;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]   = 32'h0000_0013;
    mem[31]  = 32'h0100_006F;
    mem[547] = 32'h0000_0000;

    // Reset, then reset values
    cycle(1'b0, 1'b0, BASE, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, BASE, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Single read of idx 0
    cycle(1'b1, 1'b1, 32'h0000_8000, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // idx 31 and idx 547 (last word)
    cycle(1'b1, 1'b1, 32'h0000_807C, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_888C, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Back-to-back reads idx 0..3
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, BASE + 32'(4 * i), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Stall: continuous requests with r_ready low, then release
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, BASE + 32'(4 * (10 + i)), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, BASE + 32'(4 * (20 + i)), 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Error responses: write, idx 548, outside window
    cycle(1'b1, 1'b1, 32'h0000_8000, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_8890, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset with responses buffered and in flight
    cycle(1'b1, 1'b1, BASE + 32'd20, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, BASE + 32'd24, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, BASE + 32'd28, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, BASE, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      ra = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      else if (kind == 7) ra = BASE + 32'(4 * $urandom_range(WORDS, 1023));
      else if (kind == 8) ra = $urandom;
      else                ra = BASE + 32'(4 * $urandom_range(WORDS - 1, WORDS));
      ra[1:0] = 2'($urandom);
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0), ra,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7), 1'b1);
    end
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
